// File: rtl/pipe_skid_reg.sv
// Pipeline register with valid/ready handshake and a two-entry skid buffer.
// Registered ready/valid; strict FIFO order; synchronous flush.
module pipe_skid_reg #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic [1:0]        o_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic main_vld_q, main_vld_d;
  logic skid_vld_q, skid_vld_d;

  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic accept;
  logic drain;
  logic main_ld;
  logic main_from_skid;
  logic skid_ld;

  // Handshake terms use only flops on our side: no comb ready path.
  assign accept = i_valid & ~skid_vld_q;
  assign drain  = main_vld_q & i_ready;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) state_d = S_ONE;
        end
        S_ONE: begin
          if (accept && !drain) begin
            state_d = S_FULL;
          end else if (!accept && drain) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (drain) state_d = S_ONE;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (!i_flush) begin
      unique case (state_q)
        S_EMPTY: begin
          main_ld = accept;
        end
        S_ONE: begin
          main_ld = accept & drain;
          skid_ld = accept & ~drain;
        end
        S_FULL: begin
          main_ld        = drain;
          main_from_skid = drain;
        end
        default: begin
          main_ld = 1'b0;
        end
      endcase
    end
  end

  // Valid bits are flopped from the next state so outputs leave straight from registers.
  always_comb begin
    main_vld_d = (state_d != S_EMPTY);
    skid_vld_d = (state_d == S_FULL);
  end

  always_comb begin
    main_d = main_q;
    if (main_ld) begin
      main_d = main_from_skid ? skid_q : i_data;
    end
  end

  always_comb begin
    skid_d = skid_q;
    if (skid_ld) begin
      skid_d = i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign o_valid = main_vld_q;
  assign o_ready = ~skid_vld_q;
  assign o_data  = main_q;
  assign o_count = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

endmodule
